apb4_archinfo: RTL and testbench
================================

// Module: apb4_archinfo
// PURPOSE
// - APB4 slave exposing architecture/identification registers to software.
// - Sits on the peripheral APB bus; software reads chip ID words and a RW system-config word.
// - Zero-wait-state slave; one RW register (SYS) and two RO constant registers (IDL, IDH).
// PARAMETERS
// - SYS_RST  32'h0000_0000  reset value of SYS register
// - IDL_VAL  32'h2023_0101  constant returned by IDL (build date, BCD yyyy_mmdd)
// - IDH_VAL  32'h0001_0001  constant returned by IDH ([31:16] vendor id, [15:0] version)
// PORTS
// - clk_i    in   1   APB clock (PCLK); all state updates on rising edge
// - rst_i    in   1   synchronous reset, active-high
// - paddr    in   32  byte address; decode uses paddr[3:2], paddr[31:4] ignored
// - pprot    in   3   ignored
// - psel     in   1   slave select
// - penable  in   1   access phase
// - pwrite   in   1   1=write, 0=read
// - pwdata   in   32  write data
// - pstrb    in   4   byte-lane write strobes
// - pready   out  1   transfer ready
// - prdata   out  32  read data
// - pslverr  out  1   transfer error
// BEHAVIOUR
// - Reset: rst_i high at posedge clk_i -> SYS <= SYS_RST; pready=1, pslverr=0, prdata=0 when idle.
// - Register map (paddr[3:2]): 0 SYS RW @0x00; 1 IDL RO @0x04; 2 IDH RO @0x08; 3 unmapped @0x0C.
// - pready tied 1: every transfer completes in its access phase (setup + 1 access cycle).
// - Write commits on posedge when psel&penable&pwrite&(paddr[3:2]==0); SYS visible next cycle.
// - Read: prdata combinational from paddr[3:2] while psel&penable&~pwrite; else prdata=0.
// - SYS read returns current SYS; IDL/IDH return IDL_VAL/IDH_VAL.
// - pslverr=1 only in access phase for: write to IDL/IDH, or any access to 0x0C; state unchanged.
// - pslverr=0 outside access phase and for all legal accesses.
// - Setup phase only (psel=1, penable=0): no state change, no error.
// - Reset during a transfer: reset wins; write in that cycle is discarded.
// - Back-to-back transfers (access followed directly by setup) supported with no stall.
// CONFIGURATION
// - Macro ARCHINFO_PSTRB_EN:
//   defined   -> SYS byte lane n updated only if pstrb[n]=1; pstrb=0 write is a no-op (no error).
//   undefined -> pstrb ignored; SYS written full 32 bits on every legal write.
// TESTING
// - Reset 40 cycles, read 0x00/0x04/0x08 -> 0x0000_0000 / 0x2023_0101 / 0x0001_0001, pslverr=0.
// - Write 0x00=0xDEAD_BEEF, pstrb=4'hF, read 0x00 -> 0xDEAD_BEEF, pslverr=0.
// - Write 0x04=0x1234_5678 -> pslverr=1; read 0x04 -> 0x2023_0101 unchanged.
// - Read 0x0C -> pslverr=1, prdata=0; write 0x0C -> pslverr=1, SYS unchanged.
// - ARCHINFO_PSTRB_EN: SYS=0xDEAD_BEEF, write 0x00=0x1122_3344 pstrb=4'b0101 -> read 0xDE22_BE44.
// - Assert rst_i after SYS=0xDEAD_BEEF -> read 0x00 -> 0x0000_0000 (SYS_RST).

Source files
------------

// File: rtl/apb4_archinfo_if.sv
// apb4_archinfo_if
// APB4 bus bundle between a peripheral-bus master and the archinfo slave.
//   paddr/pprot/psel/penable/pwrite/pwdata/pstrb : master -> slave
//   pready/prdata/pslverr                         : slave  -> master
interface apb4_archinfo_if;
   logic [31:0] paddr;
   logic [2:0]  pprot;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;

   modport master (
      output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/apb4_archinfo.sv
// apb4_archinfo
// Zero-wait-state APB4 slave holding identification registers.
//   0x00 SYS  RW  system-config word (reset SYS_RST)
//   0x04 IDL  RO  IDL_VAL (build date, BCD yyyy_mmdd)
//   0x08 IDH  RO  IDH_VAL ([31:16] vendor id, [15:0] version)
//   0x0C      --  unmapped, any access errors
// Ports:
//   clk_i  APB clock, all state on rising edge
//   rst_i  synchronous reset, active-high
//   apb    APB4 slave modport (pready tied high, prdata/pslverr combinational)
// Build option:
//   ARCHINFO_PSTRB_EN  defined   -> SYS written per byte lane under pstrb
//                      undefined -> pstrb ignored, full-word SYS writes
module apb4_archinfo #(
   parameter logic [31:0] SYS_RST = 32'h0000_0000,
   parameter logic [31:0] IDL_VAL = 32'h2023_0101,
   parameter logic [31:0] IDH_VAL = 32'h0001_0001
) (
   input  logic             clk_i,
   input  logic             rst_i,
   apb4_archinfo_if.slave   apb
);

   localparam logic [1:0] A_SYS = 2'd0;
   localparam logic [1:0] A_IDL = 2'd1;
   localparam logic [1:0] A_IDH = 2'd2;
   localparam logic [1:0] A_NA  = 2'd3;

   logic [31:0] sys_q;
   logic [1:0]  reg_sel;
   logic        access;
   logic        wr_sys;

   assign reg_sel = apb.paddr[3:2];
   assign access  = apb.psel & apb.penable;
   assign wr_sys  = access & apb.pwrite & (reg_sel == A_SYS);

   // Inputs the decode deliberately does not look at.
   logic unused_inputs;
`ifdef ARCHINFO_PSTRB_EN
   assign unused_inputs = ^{apb.pprot, apb.paddr[31:4], apb.paddr[1:0]};
`else
   assign unused_inputs = ^{apb.pprot, apb.paddr[31:4], apb.paddr[1:0], apb.pstrb};
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sys_q <= SYS_RST;
      end else if (wr_sys) begin
`ifdef ARCHINFO_PSTRB_EN
         for (int i = 0; i < 4; i++) begin
            if (apb.pstrb[i]) sys_q[8*i +: 8] <= apb.pwdata[8*i +: 8];
         end
`else
         sys_q <= apb.pwdata;
`endif
      end
   end

   assign apb.pready = 1'b1;

   always_comb begin
      apb.prdata = 32'h0;
      if (access && !apb.pwrite) begin
         case (reg_sel)
            A_SYS:   apb.prdata = sys_q;
            A_IDL:   apb.prdata = IDL_VAL;
            A_IDH:   apb.prdata = IDH_VAL;
            default: apb.prdata = 32'h0;
         endcase
      end
   end

   // Writes to the RO words and anything at 0x0C are rejected in the access phase.
   always_comb begin
      apb.pslverr = 1'b0;
      if (access) begin
         if (reg_sel == A_NA)
            apb.pslverr = 1'b1;
         else if (apb.pwrite && (reg_sel == A_IDL || reg_sel == A_IDH))
            apb.pslverr = 1'b1;
      end
   end

endmodule

// File: tb/tb_apb4_archinfo.sv
module tb_apb4_archinfo;

   localparam logic [31:0] SYS_RST = 32'h0000_0000;
   localparam logic [31:0] IDL_VAL = 32'h2023_0101;
   localparam logic [31:0] IDH_VAL = 32'h0001_0001;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;

   apb4_archinfo_if apb ();

   apb4_archinfo dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .apb   (apb.slave)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] sys_model;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Setup phase on one cycle, access phase on the next; the result is
   // sampled mid-cycle of the access phase and matched against the scoreboard.
   task automatic apb_xfer(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
      exp_t e;
      e.tag = tag;
      e.err = (addr[3:2] == 2'd3) || (wr && addr[3:2] != 2'd0);
      e.rdata = 32'h0;
      if (!wr) begin
         case (addr[3:2])
            2'd0: e.rdata = sys_model;
            2'd1: e.rdata = IDL_VAL;
            2'd2: e.rdata = IDH_VAL;
            default: e.rdata = 32'h0;
         endcase
      end
      sb_q.push_back(e);

      @(negedge clk_i);
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr;
      apb.paddr = addr; apb.pwdata = wdata; apb.pstrb = strb;
      apb.pprot = 3'($urandom_range(0, 7));
      #1;
      check_val({tag, "_setup_err"}, 32'(apb.pslverr), 32'h0);

      @(negedge clk_i);
      apb.penable = 1'b1;
      #1;
      if (sb_q.size() == 0) begin
         check_val({tag, "_sb_empty"}, 32'h1, 32'h0);
      end else begin
         e = sb_q.pop_front();
         check_val({e.tag, "_prdata"}, apb.prdata, e.rdata);
         check_val({e.tag, "_pslverr"}, 32'(apb.pslverr), 32'(e.err));
         check_val({e.tag, "_pready"}, 32'(apb.pready), 32'h1);
      end

      @(posedge clk_i);
      if (wr && !e.err && !rst_i) begin
`ifdef ARCHINFO_PSTRB_EN
         for (int i = 0; i < 4; i++)
            if (strb[i]) sys_model[8*i +: 8] = wdata[8*i +: 8];
`else
         sys_model = wdata;
`endif
      end
      #1;
      apb.psel = 1'b0; apb.penable = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk_i);
      rst_i = 1'b1;
      repeat (cycles) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      sys_model = SYS_RST;
   endtask

   initial begin
      logic [31:0] rw;
      logic [1:0]  ra;
      apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
      apb.paddr = 32'h0; apb.pwdata = 32'h0; apb.pstrb = 4'h0; apb.pprot = 3'h0;
      sys_model = SYS_RST;

      do_reset(40);
      #2;
      check_val("idle_pready", 32'(apb.pready), 32'h1);
      check_val("idle_pslverr", 32'(apb.pslverr), 32'h0);
      check_val("idle_prdata", apb.prdata, 32'h0);

      apb_xfer("rd_sys_rst", 1'b0, 32'h0000_0000, 32'h0, 4'hF);
      apb_xfer("rd_idl", 1'b0, 32'h0000_0004, 32'h0, 4'hF);
      apb_xfer("rd_idh", 1'b0, 32'h0000_0008, 32'h0, 4'hF);

      apb_xfer("wr_sys", 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF);
      apb_xfer("rd_sys", 1'b0, 32'h0000_0000, 32'h0, 4'hF);

      apb_xfer("wr_idl", 1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF);
      apb_xfer("rd_idl2", 1'b0, 32'h0000_0004, 32'h0, 4'hF);
      apb_xfer("wr_idh", 1'b1, 32'h0000_0008, 32'h1234_5678, 4'hF);
      apb_xfer("rd_idh2", 1'b0, 32'h0000_0008, 32'h0, 4'hF);

      apb_xfer("rd_0c", 1'b0, 32'h0000_000C, 32'h0, 4'hF);
      apb_xfer("wr_0c", 1'b1, 32'h0000_000C, 32'h5555_AAAA, 4'hF);
      apb_xfer("rd_sys_after0c", 1'b0, 32'h0000_0000, 32'h0, 4'hF);

      // High address bits ignored by decode.
      apb_xfer("rd_alias_idl", 1'b0, 32'hFFFF_FFF4, 32'h0, 4'hF);

      apb_xfer("wr_strb", 1'b1, 32'h0000_0000, 32'h1122_3344, 4'b0101);
      apb_xfer("rd_strb", 1'b0, 32'h0000_0000, 32'h0, 4'hF);
      apb_xfer("wr_strb0", 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'b0000);
      apb_xfer("rd_strb0", 1'b0, 32'h0000_0000, 32'h0, 4'hF);

      for (int i = 0; i < 24; i++) begin
         rw = $urandom;
         ra = 2'($urandom_range(0, 3));
         apb_xfer($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                  {28'($urandom), ra, 2'b00}, rw, 4'($urandom_range(0, 15)));
      end

      apb_xfer("wr_pre_rst", 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF);
      do_reset(3);
      apb_xfer("rd_post_rst", 1'b0, 32'h0000_0000, 32'h0, 4'hF);

      // Reset asserted in the access phase of a SYS write discards the write.
      apb_xfer("wr_pre_rst2", 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF);
      @(negedge clk_i);
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
      apb.paddr = 32'h0; apb.pwdata = 32'h7777_7777; apb.pstrb = 4'hF;
      @(negedge clk_i);
      apb.penable = 1'b1;
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      apb.psel = 1'b0; apb.penable = 1'b0;
      sys_model = SYS_RST;
      apb_xfer("rd_rst_mid_wr", 1'b0, 32'h0000_0000, 32'h0, 4'hF);

      check_val("sb_drained", 32'(sb_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
